// File: rtl/thor2022_prefix_fold.sv
// Folds EXI/EXIM immediate-extension prefixes into the following instruction and
// hands decode one registered bundle per non-prefix instruction.
module thor2022_prefix_fold #(
    parameter int          IW       = 64,
    parameter int          AW       = 64,
    parameter int          OPC_LSB  = 1,
    parameter logic [7:0]  EXI8_OP  = 8'h50,
    parameter logic [7:0]  EXI24_OP = 8'h52,
    parameter logic [7:0]  EXI40_OP = 8'h54,
    parameter logic [7:0]  EXI56_OP = 8'h56,
    parameter logic [7:0]  EXIM_OP  = 8'h58
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [IW-1:0] in_ir_i,
    input  logic [AW-1:0] in_pc_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [IW-1:0] ir_o,
    output logic [IW-1:0] xir_o,
    output logic          xval_o,
    output logic [IW-1:0] mir_o,
    output logic          mval_o,
    output logic [AW-1:0] pc_o,
    output logic          pfx_err_o,
    output logic          irq_ok_o
);

    // Chain state is fully implied by the two hold valids: {hm_v, hx_v}.
    typedef enum logic [1:0] {
        CH_EMPTY = 2'b00,
        CH_XONLY = 2'b01,
        CH_MONLY = 2'b10,
        CH_XM    = 2'b11
    } chain_state_t;

    logic [IW-1:0] hx;
    logic          hx_v;
    logic [IW-1:0] hm;
    logic          hm_v;
    logic [AW-1:0] hpc;
    logic          hpc_v;
    logic          herr;

    chain_state_t  chain_state;

    logic [7:0]    opc;
    logic          is_exi;
    logic          is_exim;
    logic          accept;
    logic          take_x;
    logic          take_m;
    logic          take_ins;

    always_comb begin
        opc         = in_ir_i[OPC_LSB +: 8];
        is_exi      = (opc[7:1] == EXI8_OP[7:1])  || (opc[7:1] == EXI24_OP[7:1]) ||
                      (opc[7:1] == EXI40_OP[7:1]) || (opc[7:1] == EXI56_OP[7:1]);
        is_exim     = (opc == EXIM_OP);
        in_ready_o  = !flush_i && (!out_valid_o || out_ready_i);
        accept      = in_valid_i && in_ready_o;
        take_x      = accept && is_exi;
        take_m      = accept && is_exim;
        take_ins    = accept && !is_exi && !is_exim;
        chain_state = chain_state_t'({hm_v, hx_v});
        irq_ok_o    = (chain_state == CH_EMPTY);
    end

    // Holding registers for the prefix chain in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hx    <= '0;
            hx_v  <= 1'b0;
            hm    <= '0;
            hm_v  <= 1'b0;
            hpc   <= '0;
            hpc_v <= 1'b0;
            herr  <= 1'b0;
        end else if (flush_i || take_ins) begin
            hx_v  <= 1'b0;
            hm_v  <= 1'b0;
            hpc_v <= 1'b0;
            herr  <= 1'b0;
        end else if (take_x || take_m) begin
            if (take_x) begin
                hx   <= in_ir_i;
                hx_v <= 1'b1;
                if (hx_v) begin
                    herr <= 1'b1;
                end
            end
            if (take_m) begin
                hm   <= in_ir_i;
                hm_v <= 1'b1;
                if (hm_v) begin
                    herr <= 1'b1;
                end
            end
            // The chain PC is the PC of whichever prefix arrived first.
            if (!hpc_v) begin
                hpc   <= in_pc_i;
                hpc_v <= 1'b1;
            end
        end
    end

    // Decode bundle register; an accept in the consume cycle replaces it with no bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o <= 1'b0;
            ir_o        <= '0;
            xir_o       <= '0;
            xval_o      <= 1'b0;
            mir_o       <= '0;
            mval_o      <= 1'b0;
            pc_o        <= '0;
            pfx_err_o   <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (take_ins) begin
            out_valid_o <= 1'b1;
            ir_o        <= in_ir_i;
            xir_o       <= hx_v ? hx : '0;
            xval_o      <= hx_v;
            mir_o       <= hm_v ? hm : '0;
            mval_o      <= hm_v;
            pc_o        <= hpc_v ? hpc : in_pc_i;
            pfx_err_o   <= herr;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_thor2022_prefix_fold.sv
// Directed and randomized checks of prefix folding, handshake, flush and reset.
module tb_thor2022_prefix_fold;

    localparam int IW = 64;
    localparam int AW = 64;
    localparam int BW = 3 * IW + AW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_ir = '0;
    logic [AW-1:0] in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [IW-1:0] ir_q, xir_q, mir_q;
    logic          xval, mval, pfx_err, irq_ok;
    logic [AW-1:0] pc_q;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] exp_q[$];

    thor2022_prefix_fold dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_ir_i(in_ir), .in_pc_i(in_pc),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .ir_o(ir_q), .xir_o(xir_q), .xval_o(xval), .mir_o(mir_q), .mval_o(mval),
        .pc_o(pc_q), .pfx_err_o(pfx_err), .irq_ok_o(irq_ok)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] mk(input logic [7:0] opc, input logic [IW-1:0] payload);
        logic [IW-1:0] w;
        w = payload;
        w[8:1] = opc;
        return w;
    endfunction

    function automatic bit opc_is_pfx(input logic [IW-1:0] w);
        logic [7:0] o;
        o = w[8:1];
        return (o >= 8'h50 && o <= 8'h58);
    endfunction

    function automatic logic [BW-1:0] dut_bundle();
        return {ir_q, xir_q, xval, mir_q, mval, pc_q, pfx_err};
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, xval, mval, pfx_err} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {out_valid, xval, mval, pfx_err});
        end
        checks++;
        if (ir_q !== '0 || xir_q !== '0 || mir_q !== '0 || pc_q !== '0) begin
            errors++; $display("FAIL reset_data got ir %h pc %h exp 0", ir_q, pc_q);
        end
        checks++;
        if (irq_ok !== 1'b1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_irq_rdy got %b%b exp 11", irq_ok, in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_plain;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_ir = 64'h0000_0000_0000_1234;
        in_pc = 64'h100;
        tick();
        in_valid = 1'b0;
        checks++;
        if (dut_bundle() !== {64'h1234, 64'h0, 1'b0, 64'h0, 1'b0, 64'h100, 1'b0} || out_valid !== 1'b1) begin
            errors++; $display("FAIL plain_bundle got v=%b %h pc %h", out_valid, ir_q, pc_q);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL plain_consume got %b exp 0", out_valid);
        end
    endtask

    task automatic test_folded_chain;
        logic [IW-1:0] exi, exim, addi;
        exi  = mk(8'h53, 64'hAAAA_0000_1111_0000);
        exim = mk(8'h58, 64'hBBBB_0000_2222_0000);
        addi = mk(8'h10, 64'hCCCC_0000_3333_0000);
        out_ready = 1'b1;
        in_valid = 1'b1; in_ir = exi; in_pc = 64'h200;
        tick();
        checks++;
        if (out_valid !== 1'b0 || irq_ok !== 1'b0) begin
            errors++; $display("FAIL chain_after_exi got v=%b irq=%b exp 0 0", out_valid, irq_ok);
        end
        in_ir = exim; in_pc = 64'h208;
        tick();
        checks++;
        if (out_valid !== 1'b0 || irq_ok !== 1'b0) begin
            errors++; $display("FAIL chain_after_exim got v=%b irq=%b exp 0 0", out_valid, irq_ok);
        end
        in_ir = addi; in_pc = 64'h210;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || dut_bundle() !== {addi, exi, 1'b1, exim, 1'b1, 64'h200, 1'b0}) begin
            errors++; $display("FAIL chain_bundle got %h exp ir %h pc 200", dut_bundle(), addi);
        end
        checks++;
        if (irq_ok !== 1'b1) begin
            errors++; $display("FAIL chain_irq_ok got %b exp 1", irq_ok);
        end
        tick();
    endtask

    task automatic test_back_pressure;
        logic [IW-1:0] a, exi, b;
        a   = mk(8'h22, 64'h1);
        exi = mk(8'h56, 64'h5555_0000);
        b   = mk(8'h30, 64'h7);
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = a; in_pc = 64'h400;
        tick();
        in_ir = exi; in_pc = 64'h408;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || ir_q !== a || irq_ok !== 1'b1) begin
                errors++; $display("FAIL bp_hold cyc %0d got v=%b ir %h irq=%b", i, out_valid, ir_q, irq_ok);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b exp 1", in_ready);
        end
        tick();
        checks++;
        if (irq_ok !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_absorb got irq=%b v=%b exp 0 0", irq_ok, out_valid);
        end
        in_ir = b; in_pc = 64'h410;
        tick();
        in_valid = 1'b0;
        checks++;
        if (dut_bundle() !== {b, exi, 1'b1, 64'h0, 1'b0, 64'h408, 1'b0}) begin
            errors++; $display("FAIL bp_bundle got %h", dut_bundle());
        end
        tick();
    endtask

    task automatic test_duplicate;
        logic [IW-1:0] e8, e40, ld, nx;
        e8  = mk(8'h51, 64'h8888_0000);
        e40 = mk(8'h54, 64'h4040_0000);
        ld  = mk(8'h40, 64'h1D00);
        nx  = mk(8'h12, 64'h9900);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_ir = e8;  in_pc = 64'h300; tick();
        in_ir = e40; in_pc = 64'h308; tick();
        in_ir = ld;  in_pc = 64'h310; tick();
        checks++;
        if (dut_bundle() !== {ld, e40, 1'b1, 64'h0, 1'b0, 64'h300, 1'b1}) begin
            errors++; $display("FAIL dup_bundle got xir %h pc %h err %b", xir_q, pc_q, pfx_err);
        end
        in_ir = nx; in_pc = 64'h318; tick();
        in_valid = 1'b0;
        checks++;
        if (dut_bundle() !== {nx, 64'h0, 1'b0, 64'h0, 1'b0, 64'h318, 1'b0}) begin
            errors++; $display("FAIL dup_next_clean got err %b xval %b pc %h", pfx_err, xval, pc_q);
        end
        tick();
    endtask

    task automatic test_flush;
        logic [IW-1:0] exim, p;
        exim = mk(8'h58, 64'hE000);
        p    = mk(8'h11, 64'h7700);
        out_ready = 1'b1;
        in_valid = 1'b1; in_ir = exim; in_pc = 64'h500;
        tick();
        checks++;
        if (irq_ok !== 1'b0) begin
            errors++; $display("FAIL flush_held got irq=%b exp 0", irq_ok);
        end
        flush = 1'b1; in_ir = p; in_pc = 64'h508;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL flush_ready got %b exp 0", in_ready);
        end
        tick();
        flush = 1'b0;
        checks++;
        if (irq_ok !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear got irq=%b v=%b exp 1 0", irq_ok, out_valid);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (dut_bundle() !== {p, 64'h0, 1'b0, 64'h0, 1'b0, 64'h508, 1'b0} || out_valid !== 1'b1) begin
            errors++; $display("FAIL flush_next got mval %b pc %h", mval, pc_q);
        end
        // Flush must drop a pending bundle even while decode is ready.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_bundle got %b exp 0", out_valid);
        end
    endtask

    task automatic test_async_reset;
        logic [IW-1:0] exi, p;
        exi = mk(8'h52, 64'h2400);
        p   = mk(8'h13, 64'h3300);
        out_ready = 1'b1;
        in_valid = 1'b1; in_ir = exi; in_pc = 64'h600;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (irq_ok !== 1'b1) begin
            errors++; $display("FAIL areset_hold got irq=%b exp 1", irq_ok);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = p; in_pc = 64'h610;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || xval !== 1'b0 || pc_q !== 64'h610) begin
            errors++; $display("FAIL areset_discard got v=%b xval=%b pc %h", out_valid, xval, pc_q);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || ir_q !== '0) begin
            errors++; $display("FAIL areset_out got v=%b ir %h exp 0", out_valid, ir_q);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random;
        localparam int N = 400;
        logic [IW-1:0] s_ir[$];
        logic [AW-1:0] s_pc[$];
        logic [IW-1:0] w, x, m;
        logic [AW-1:0] cpc;
        logic [7:0]    o;
        logic [BW-1:0] got, exp;
        bit            xv, mv, pv, er, held, exp_rdy;
        int            idx, cyc, r;
        for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 99);
            if (i == N - 1 || r >= 45)
                o = 8'h60 + 8'($urandom_range(0, 150));
            else if (r < 30)
                o = 8'h50 + 8'($urandom_range(0, 7));
            else
                o = 8'h58;
            w = {$urandom, $urandom};
            s_ir.push_back(mk(o, w));
            s_pc.push_back(64'h1000 + 64'(i * 8));
        end
        // Expected bundles: walk the stream, folding prefixes into the next plain instruction.
        xv = 0; mv = 0; pv = 0; er = 0; x = '0; m = '0; cpc = '0;
        for (int i = 0; i < N; i++) begin
            o = s_ir[i][8:1];
            if (o >= 8'h50 && o <= 8'h57) begin
                if (xv) er = 1;
                xv = 1; x = s_ir[i];
                if (!pv) begin pv = 1; cpc = s_pc[i]; end
            end else if (o == 8'h58) begin
                if (mv) er = 1;
                mv = 1; m = s_ir[i];
                if (!pv) begin pv = 1; cpc = s_pc[i]; end
            end else begin
                exp_q.push_back({s_ir[i], xv ? x : 64'h0, xv, mv ? m : 64'h0, mv,
                                 pv ? cpc : s_pc[i], er});
                xv = 0; mv = 0; pv = 0; er = 0;
            end
        end
        idx = 0; cyc = 0; held = 0;
        while ((idx < N || exp_q.size() > 0) && cyc < 20000) begin
            in_valid = (idx < N) && ($urandom_range(0, 3) != 0);
            if (idx < N) begin in_ir = s_ir[idx]; in_pc = s_pc[idx]; end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = !out_valid || out_ready;
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, in_ready, exp_rdy);
            end
            checks++;
            if (irq_ok !== !held) begin
                errors++; $display("FAIL rnd_irq cyc %0d got %b exp %b", cyc, irq_ok, !held);
            end
            if (out_valid === 1'b1 && out_ready) begin
                got = dut_bundle();
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra cyc %0d got %h exp none", cyc, got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++; $display("FAIL rnd_bundle cyc %0d got %h exp %h", cyc, got, exp);
                    end
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                held = opc_is_pfx(s_ir[idx]);
                idx++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc >= 20000) begin
            errors++; $display("FAIL rnd_timeout got idx %0d pending %0d exp done", idx, exp_q.size());
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rnd_drain got v=%b exp 0", out_valid);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_plain();
        test_folded_chain();
        test_back_pressure();
        test_duplicate();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
